// File: rtl/guess_game_ctrl_if.sv
// Player-side handshake bundle for the guess-the-number controller.
// Pulses and switches flow in; display digit, hints and status flow out.
interface guess_game_ctrl_if;
  logic       start;
  logic       submit;
  logic [3:0] guess_in;
  logic [3:0] num;
  logic       too_high;
  logic       too_low;
  logic       win;
  logic       lose;
  logic [3:0] tries_left;

  modport master (
    output start, submit, guess_in,
    input  num, too_high, too_low, win, lose, tries_left
  );

  modport slave (
    input  start, submit, guess_in,
    output num, too_high, too_low, win, lose, tries_left
  );
endinterface

// File: rtl/guess_game_ctrl.sv
// Guess-the-number game controller: LFSR target, hint flags, tries count.
// Every output is a register; num feeds seven_seg_display (4'hF blanks).
module guess_game_ctrl #(
  parameter int unsigned MAX_TRIES = 7,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  guess_game_ctrl_if.slave  gif
);

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    CHECK,
    WIN,
    LOSE
  } state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);
  localparam logic [3:0] BLANK = 4'hF;

  state_t     state_q, state_n;
  logic [7:0] lfsr;
  logic       fb;
  logic [3:0] cap;
  logic [3:0] target_q, target_n;
  logic [3:0] guess_q, guess_n;
  logic [3:0] num_q, num_n;
  logic       hi_q, hi_n;
  logic       lo_q, lo_n;
  logic       win_q, win_n;
  logic       lose_q, lose_n;
  logic [3:0] tries_q, tries_n;

  assign fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  // fold 10..15 back into 0..5 so the target is always a digit
  assign cap = (lfsr[3:0] > 4'd9) ? lfsr[3:0] - 4'd10 : lfsr[3:0];

  always_comb begin
    state_n  = state_q;
    target_n = target_q;
    guess_n  = guess_q;
    hi_n     = hi_q;
    lo_n     = lo_q;
    win_n    = win_q;
    lose_n   = lose_q;
    tries_n  = tries_q;
    if (gif.start) begin
      state_n  = PLAY;
      target_n = cap;
      tries_n  = MAX_T;
      hi_n     = 1'b0;
      lo_n     = 1'b0;
      win_n    = 1'b0;
      lose_n   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        PLAY: begin
          if (gif.submit && gif.guess_in <= 4'd9) begin
            guess_n = gif.guess_in;
            state_n = CHECK;
          end
        end
        CHECK: begin
          if (guess_q == target_q) begin
            state_n = WIN;
            win_n   = 1'b1;
            hi_n    = 1'b0;
            lo_n    = 1'b0;
          end else begin
            hi_n = guess_q > target_q;
            lo_n = guess_q < target_q;
            if (tries_q <= 4'd1) begin
              tries_n = 4'd0;
              lose_n  = 1'b1;
              state_n = LOSE;
            end else begin
              tries_n = tries_q - 4'd1;
              state_n = PLAY;
            end
          end
        end
        WIN:  ;
        LOSE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    num_n = BLANK;
    unique case (state_n)
      IDLE:        num_n = BLANK;
      PLAY, CHECK: num_n = gif.guess_in;
      WIN, LOSE:   num_n = target_n;
      default:     num_n = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr     <= LFSR_SEED;
      target_q <= 4'd0;
      guess_q  <= 4'd0;
      num_q    <= BLANK;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      tries_q  <= 4'd0;
    end else begin
      state_q  <= state_n;
      lfsr     <= {lfsr[6:0], fb};
      target_q <= target_n;
      guess_q  <= guess_n;
      num_q    <= num_n;
      hi_q     <= hi_n;
      lo_q     <= lo_n;
      win_q    <= win_n;
      lose_q   <= lose_n;
      tries_q  <= tries_n;
    end
  end

  assign gif.num        = num_q;
  assign gif.too_high   = hi_q;
  assign gif.too_low    = lo_q;
  assign gif.win        = win_q;
  assign gif.lose       = lose_q;
  assign gif.tries_left = tries_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Randomized self-checking bench for guess_game_ctrl.
// A game-level model predicts target, hints, tries and status.
module tb_guess_game_ctrl;
  localparam int         MAXT = 7;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  guess_game_ctrl_if gif();

  guess_game_ctrl #(
    .MAX_TRIES(MAXT),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gif(gif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_lfsr;
  always @(posedge clk)
    m_lfsr <= rst ? SEED :
      {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  bit         m_play, m_won, m_lost, m_hi, m_lo;
  logic [3:0] m_tgt, m_tries;

  function automatic logic [3:0] map_tgt(logic [3:0] v);
    return (v > 9) ? v - 4'd10 : v;
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [3:0] n;
    n = (m_won || m_lost) ? m_tgt : (m_play ? gif.guess_in : 4'hF);
    return {n, m_hi, m_lo, m_won, m_lost, m_tries};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {gif.num, gif.too_high, gif.too_low,
            gif.win, gif.lose, gif.tries_left};
  endfunction

  task automatic m_reset();
    m_play = 0; m_won = 0; m_lost = 0;
    m_hi = 0; m_lo = 0; m_tries = 0; m_tgt = 0;
  endtask

  task automatic m_start();
    m_tgt = map_tgt(m_lfsr[3:0]);
    m_tries = 4'(MAXT);
    m_play = 1; m_won = 0; m_lost = 0;
    m_hi = 0; m_lo = 0;
  endtask

  task automatic m_submit(logic [3:0] g);
    if (!m_play || g > 9) return;
    if (g == m_tgt) begin
      m_won = 1; m_play = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_hi = g > m_tgt;
      m_lo = g < m_tgt;
      if (m_tries == 1) begin
        m_tries = 0; m_lost = 1; m_play = 0;
      end else m_tries = m_tries - 1;
    end
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1; gif.start = 0; gif.submit = 0;
    repeat (n) @(negedge clk);
    rst = 0;
    m_reset();
  endtask

  task automatic do_start();
    m_start();
    gif.start = 1;
    @(negedge clk);
    gif.start = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_submit(logic [3:0] g);
    gif.guess_in = g;
    gif.submit = 1;
    m_submit(g);
    @(negedge clk);
    gif.submit = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(3);
    n_chk++;
    if (obs_vec() !== 12'hF00) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", obs_vec(), 12'hF00);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs_vec() !== 12'hF00) begin
      n_fail++;
      $display("FAIL idle_hold: got %h expected %h", obs_vec(), 12'hF00);
    end
  endtask

  task automatic test_win_path();
    logic [11:0] want [3];
    logic [3:0]  g [3];
    want[0] = {4'd3, 1'b0, 1'b1, 2'b00, 4'd6};
    want[1] = {4'd8, 1'b1, 1'b0, 2'b00, 4'd5};
    want[2] = {4'd5, 1'b0, 1'b0, 2'b10, 4'd5};
    g[0] = 3; g[1] = 8; g[2] = 5;
    do_reset(3);
    gif.guess_in = 0;
    do_start();
    n_chk++;
    if (obs_vec() !== {4'd0, 4'b0000, 4'd7}) begin
      n_fail++;
      $display("FAIL win_start: got %h expected %h",
               obs_vec(), {4'd0, 4'b0000, 4'd7});
    end
    for (int i = 0; i < 3; i++) begin
      do_submit(g[i]);
      n_chk++;
      if (obs_vec() !== want[i]) begin
        n_fail++;
        $display("FAIL win_step%0d: got %h expected %h",
                 i, obs_vec(), want[i]);
      end
    end
  endtask

  task automatic test_lose_path();
    do_reset(3);
    gif.guess_in = 0;
    do_start();
    for (int i = 0; i < MAXT + 2; i++) begin
      do_submit(4'd0);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL lose_step%0d: got %h expected %h",
                 i, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (obs_vec() !== {4'd5, 1'b0, 1'b1, 2'b01, 4'd0}) begin
      n_fail++;
      $display("FAIL lose_final: got %h expected %h",
               obs_vec(), {4'd5, 1'b0, 1'b1, 2'b01, 4'd0});
    end
  endtask

  task automatic test_invalid_guess();
    do_reset(2);
    gif.guess_in = 0;
    do_start();
    do_submit(4'd3);
    do_submit(4'd12);
    n_chk++;
    if (obs_vec() !== {4'd12, 1'b0, 1'b1, 2'b00, 4'd6}) begin
      n_fail++;
      $display("FAIL invalid_guess: got %h expected %h",
               obs_vec(), {4'd12, 1'b0, 1'b1, 2'b00, 4'd6});
    end
    do_submit(4'd9);
    n_chk++;
    if (obs_vec() !== {4'd9, 1'b1, 1'b0, 2'b00, 4'd5}) begin
      n_fail++;
      $display("FAIL after_invalid: got %h expected %h",
               obs_vec(), {4'd9, 1'b1, 1'b0, 2'b00, 4'd5});
    end
  endtask

  task automatic test_collisions();
    logic [3:0] g;
    do_start();
    g = (m_tgt == 0) ? 4'd9 : 4'd0;
    do_submit(g);
    gif.start = 1;
    gif.submit = 1;
    gif.guess_in = g;
    m_start();
    @(negedge clk);
    gif.start = 0;
    gif.submit = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs_vec() !== exp_vec() || gif.tries_left !== 4'(MAXT)) begin
      n_fail++;
      $display("FAIL start_submit: got %h expected %h",
               obs_vec(), exp_vec());
    end
    gif.submit = 1;
    @(negedge clk);
    gif.submit = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_reset();
    n_chk++;
    if (obs_vec() !== 12'hF00) begin
      n_fail++;
      $display("FAIL rst_in_check: got %h expected %h", obs_vec(), 12'hF00);
    end
  endtask

  task automatic test_lfsr();
    logic [7:0] v0;
    int cnt;
    int waited;
    @(negedge clk);
    v0 = dut.lfsr;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      n_chk++;
      if (dut.lfsr !== m_lfsr || dut.lfsr == 8'd0) begin
        n_fail++;
        $display("FAIL lfsr_seq: got %h expected %h", dut.lfsr, m_lfsr);
      end
    end while (dut.lfsr !== v0 && cnt < 300);
    n_chk++;
    if (cnt != 255) begin
      n_fail++;
      $display("FAIL lfsr_period: got %0d expected 255", cnt);
    end
    waited = 0;
    while (m_lfsr[3:0] != 4'hC && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    gif.guess_in = 0;
    do_start();
    do_submit(4'd2);
    n_chk++;
    if (waited >= 300 || gif.win !== 1'b1 || gif.num !== 4'd2) begin
      n_fail++;
      $display("FAIL capture_C: got win=%b num=%h expected win=1 num=2",
               gif.win, gif.num);
    end
  endtask

  task automatic test_random();
    for (int game = 0; game < 25; game++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      gif.guess_in = 4'($urandom_range(0, 15));
      do_start();
      for (int k = 0; k < 20; k++) begin
        if ($urandom_range(0, 14) == 0) begin
          do_start();
        end else begin
          do_submit(4'($urandom_range(0, 15)));
        end
        n_chk++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL rand_g%0d_a%0d: got %h expected %h",
                   game, k, obs_vec(), exp_vec());
        end
        if (m_won || m_lost) begin
          n_chk++;
          if (gif.num > 4'd9) begin
            n_fail++;
            $display("FAIL target_range: got %h expected 0..9", gif.num);
          end
          if (k > 17) break;
          k = 17;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    gif.start = 0;
    gif.submit = 0;
    gif.guess_in = 0;
    m_reset();
    test_reset();
    test_win_path();
    test_lose_path();
    test_invalid_guess();
    test_collisions();
    test_lfsr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
